// File: rtl/apb_i2c_seq.sv
// APB master sequencer for the APB-to-I2C bridge: config writes, TX stream, RX drain, PREADY watchdog.
// Optional build macro APB_SEQ_TX_THROTTLE_EN: TX is eligible only while the bridge TX FIFO is empty.
module apb_i2c_seq #(
    parameter logic [31:0] ADDR_TX  = 32'd0,
    parameter logic [31:0] ADDR_RX  = 32'd4,
    parameter logic [31:0] ADDR_CFG = 32'd8,
    parameter logic [31:0] ADDR_TMO = 32'd12,
    parameter int          RDY_TMO  = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cfg_start,
    input  logic [13:0] cfg_word,
    input  logic [13:0] tmo_word,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    input  logic        rx_ready,
    input  logic        err_clr,
    output logic        busy,
    output logic        cfg_done,
    output logic        err_slv,
    output logic        err_tmo,
    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        INT_RX,
    input  logic        INT_TX
);

    localparam int WDOG_W = (RDY_TMO > 1) ? $clog2(RDY_TMO) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(RDY_TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
    typedef enum logic [1:0] {OP_CFG, OP_TMO, OP_TX, OP_RX} op_t;

    state_t              r_state, w_state;
    op_t                 r_op, w_op;
    logic                r_psel, w_psel;
    logic                r_penable, w_penable;
    logic                r_pwrite, w_pwrite;
    logic [31:0]         r_paddr, w_paddr;
    logic [31:0]         r_pwdata, w_pwdata;
    logic                r_tx_ready, w_tx_ready;
    logic                r_rx_valid, w_rx_valid;
    logic [31:0]         r_rx_data, w_rx_data;
    logic                r_pend, w_pend;
    logic [13:0]         r_cfg_word, w_cfg_word;
    logic [13:0]         r_tmo_word, w_tmo_word;
    logic                r_cfg_done, w_cfg_done;
    logic                r_pref_tx, w_pref_tx;
    logic [WDOG_W-1:0]   r_wdog, w_wdog;
    logic                r_err_slv, r_err_tmo;
    logic                w_slv_hit, w_tmo_hit;
    logic                w_in_cfg;
    logic                w_rx_elig, w_tx_elig;

    assign w_rx_elig = ~INT_RX & ~r_rx_valid;
`ifdef APB_SEQ_TX_THROTTLE_EN
    assign w_tx_elig = tx_valid & INT_TX;
`else
    logic w_unused_int_tx;
    assign w_unused_int_tx = INT_TX;
    assign w_tx_elig = tx_valid;
`endif

    always_comb begin
        w_state    = r_state;
        w_op       = r_op;
        w_psel     = r_psel;
        w_penable  = r_penable;
        w_pwrite   = r_pwrite;
        w_paddr    = r_paddr;
        w_pwdata   = r_pwdata;
        w_tx_ready = 1'b0;
        w_rx_valid = r_rx_valid & ~rx_ready;
        w_rx_data  = r_rx_data;
        w_pend     = r_pend;
        w_cfg_word = r_cfg_word;
        w_tmo_word = r_tmo_word;
        w_cfg_done = r_cfg_done;
        w_pref_tx  = r_pref_tx;
        w_wdog     = r_wdog;
        w_slv_hit  = 1'b0;
        w_tmo_hit  = 1'b0;

        // A config run in flight keeps the words it started with.
        w_in_cfg = (r_state != S_IDLE) && ((r_op == OP_CFG) || (r_op == OP_TMO));
        if (cfg_start && !w_in_cfg) begin
            w_cfg_word = cfg_word;
            w_tmo_word = tmo_word;
            w_pend     = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_pend) begin
                    w_state   = S_SETUP;
                    w_op      = OP_CFG;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_pwrite  = 1'b1;
                    w_paddr   = ADDR_CFG;
                    w_pwdata  = {18'd0, w_cfg_word};
                end else if (r_cfg_done && (w_rx_elig || w_tx_elig)) begin
                    w_state   = S_SETUP;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    if (w_rx_elig && (!w_tx_elig || !r_pref_tx)) begin
                        w_op      = OP_RX;
                        w_pwrite  = 1'b0;
                        w_paddr   = ADDR_RX;
                        w_pref_tx = 1'b1;
                    end else begin
                        w_op       = OP_TX;
                        w_pwrite   = 1'b1;
                        w_paddr    = ADDR_TX;
                        w_pwdata   = tx_data;
                        w_tx_ready = 1'b1;
                        w_pref_tx  = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                w_state   = S_ACCESS;
                w_penable = 1'b1;
                w_wdog    = WDOG_LOAD;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_slv_hit = PSLVERR;
                    w_state   = S_IDLE;
                    case (r_op)
                        OP_RX: begin
                            w_rx_data  = PRDATA;
                            w_rx_valid = 1'b1;
                        end
                        OP_CFG: begin
                            w_state  = S_SETUP;
                            w_op     = OP_TMO;
                            w_psel   = 1'b1;
                            w_pwrite = 1'b1;
                            w_paddr  = ADDR_TMO;
                            w_pwdata = {18'd0, r_tmo_word};
                        end
                        OP_TMO: begin
                            w_cfg_done = 1'b1;
                            w_pend     = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (r_wdog == '0) begin
                    // Abort: TX word dropped, rx_valid untouched, config stays pending.
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_tmo_hit = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_wdog = r_wdog - 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_op       <= OP_CFG;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_pend     <= 1'b0;
            r_cfg_word <= '0;
            r_tmo_word <= '0;
            r_cfg_done <= 1'b0;
            r_pref_tx  <= 1'b0;
            r_wdog     <= '0;
            r_err_slv  <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_op       <= w_op;
            r_psel     <= w_psel;
            r_penable  <= w_penable;
            r_pwrite   <= w_pwrite;
            r_paddr    <= w_paddr;
            r_pwdata   <= w_pwdata;
            r_tx_ready <= w_tx_ready;
            r_rx_valid <= w_rx_valid;
            r_rx_data  <= w_rx_data;
            r_pend     <= w_pend;
            r_cfg_word <= w_cfg_word;
            r_tmo_word <= w_tmo_word;
            r_cfg_done <= w_cfg_done;
            r_pref_tx  <= w_pref_tx;
            r_wdog     <= w_wdog;
            r_err_slv  <= (r_err_slv & ~err_clr) | w_slv_hit;
            r_err_tmo  <= (r_err_tmo & ~err_clr) | w_tmo_hit;
        end
    end

    assign PSELx    = r_psel;
    assign PENABLE  = r_penable;
    assign PWRITE   = r_pwrite;
    assign PADDR    = r_paddr;
    assign PWDATA   = r_pwdata;
    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = (r_state != S_IDLE);
    assign cfg_done = r_cfg_done;
    assign err_slv  = r_err_slv;
    assign err_tmo  = r_err_tmo;

endmodule

// File: tb/tb_apb_i2c_seq.sv
// Directed self-checking bench for apb_i2c_seq; completed APB transfers are logged on the falling edge.
module tb_apb_i2c_seq;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cfg_start;
    logic [13:0] cfg_word, tmo_word;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready, err_clr;
    logic        busy, cfg_done, err_slv, err_tmo;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, INT_RX, INT_TX;

    apb_i2c_seq dut (
        .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start), .cfg_word(cfg_word), .tmo_word(tmo_word),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .err_clr(err_clr), .busy(busy), .cfg_done(cfg_done), .err_slv(err_slv),
        .err_tmo(err_tmo), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_RX(INT_RX),
        .INT_TX(INT_TX)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] lg_addr [64];
    logic [31:0] lg_wd   [64];
    logic        lg_wr   [64];
    int n_lg = 0, n_txr = 0, run = 0, last_run = 0, max_run = 0;

    always @(negedge PCLK) begin
        if (PSELx && PENABLE && PREADY && n_lg < 64) begin
            lg_addr[n_lg] = PADDR;
            lg_wd[n_lg]   = PWDATA;
            lg_wr[n_lg]   = PWRITE;
            n_lg++;
        end
        if (tx_ready) n_txr++;
        if (PSELx) run++;
        else if (run != 0) begin
            last_run = run;
            if (run > max_run) max_run = run;
            run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int b, t;
        logic ok;

        PRESET = 1'b1; cfg_start = 1'b0; cfg_word = '0; tmo_word = '0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; err_clr = 1'b0;
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0; INT_RX = 1'b1; INT_TX = 1'b1;
        step(3);
        chk("rst_psel", PSELx, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_errs", {err_slv, err_tmo}, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_paddr", PADDR, 0);
        PRESET = 1'b0;
        step(1);

        // TX held off until configuration has run
        tx_valid = 1'b1; tx_data = 32'hDEADBEEF;
        step(10);
        chk("precfg_xfers", n_lg, 0);
        chk("precfg_txready", n_txr, 0);
        chk("precfg_busy", busy, 0);

        b = n_lg; t = n_txr;
        cfg_word = 14'h1A5; tmo_word = 14'h3FF; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_ready) begin tx_valid = 1'b0; ok = 1'b1; break; end
            step(1);
        end
        chk("cfg_tx_ready_seen", ok, 1);
        step(4);
        chk("cfg_n_xfers", n_lg - b, 3);
        chk("cfg_addr0", lg_addr[b], 32'd8);
        chk("cfg_wd0", lg_wd[b], 32'h1A5);
        chk("cfg_addr1", lg_addr[b+1], 32'd12);
        chk("cfg_wd1", lg_wd[b+1], 32'h3FF);
        chk("cfg_wr", {lg_wr[b], lg_wr[b+1], lg_wr[b+2]}, 3'b111);
        chk("cfg_psel_run", max_run, 4);
        chk("cfg_done", cfg_done, 1);
        chk("tx_addr", lg_addr[b+2], 32'd0);
        chk("tx_wd", lg_wd[b+2], 32'hDEADBEEF);
        chk("tx_ready_once", n_txr - t, 1);

        // Round-robin: RX first after a TX, then alternate
        b = n_lg;
        PRDATA = 32'h55; rx_ready = 1'b1; tx_data = 32'h0BADF00D; tx_valid = 1'b1; INT_RX = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (n_lg - b >= 4) begin ok = 1'b1; break; end
        end
        tx_valid = 1'b0; INT_RX = 1'b1;
        chk("arb_done", ok, 1);
        chk("arb_addrs", {lg_addr[b][7:0], lg_addr[b+1][7:0], lg_addr[b+2][7:0], lg_addr[b+3][7:0]}, 32'h04000400);
        chk("arb_dirs", {lg_wr[b], lg_wr[b+1], lg_wr[b+2], lg_wr[b+3]}, 4'b0101);
        chk("arb_tx_wd", lg_wd[b+1], 32'h0BADF00D);
        chk("arb_rx_data", rx_data, 32'h55);
        step(3);
        chk("arb_quiet", n_lg - b, 4);

        // rx_valid held: only one read until consumed
        b = n_lg;
        rx_ready = 1'b0; PRDATA = 32'hA5A50077; INT_RX = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rx_valid) begin ok = 1'b1; break; end
        end
        chk("rxh_valid", ok, 1);
        chk("rxh_data", rx_data, 32'hA5A50077);
        step(8);
        chk("rxh_single_read", n_lg - b, 1);
        INT_RX = 1'b1; rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        chk("rxh_consumed", rx_valid, 0);

        // Watchdog on a TX write
        b = n_lg; t = n_txr;
        PREADY = 1'b0; tx_data = 32'hCAFE0001; tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tx_ready) begin tx_valid = 1'b0; break; end
        end
        tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (err_tmo) begin ok = 1'b1; break; end
        end
        chk("wd_err_tmo", ok, 1);
        chk("wd_psel", {PSELx, PENABLE, busy}, 3'b000);
        step(1);
        chk("wd_psel_cycles", last_run, 17);
        step(4);
        PREADY = 1'b1;
        step(5);
        chk("wd_no_retry_txr", n_txr - t, 1);
        chk("wd_no_retry_xfer", n_lg - b, 0);
        chk("wd_err_slv_clean", err_slv, 0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("wd_err_clr", err_tmo, 0);

        // Slave error during config does not stop the sequence
        b = n_lg;
        PSLVERR = 1'b1; cfg_word = 14'h2AA; tmo_word = 14'h0F0; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (n_lg - b >= 2 && !busy) break;
        end
        PSLVERR = 1'b0;
        chk("slv_err", err_slv, 1);
        chk("slv_addr0", lg_addr[b], 32'd8);
        chk("slv_wd0", lg_wd[b], 32'h2AA);
        chk("slv_addr1", lg_addr[b+1], 32'd12);
        chk("slv_wd1", lg_wd[b+1], 32'h0F0);
        chk("slv_cfg_done", cfg_done, 1);

        // Reset in the middle of the TMO access
        cfg_word = 14'h111; tmo_word = 14'h222; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (PENABLE && PADDR == 32'd12) begin ok = 1'b1; break; end
            step(1);
        end
        chk("rst_mid_found", ok, 1);
        PRESET = 1'b1;
        #1;
        chk("rst_mid_psel", {PSELx, PENABLE}, 2'b00);
        chk("rst_mid_cfg_done", cfg_done, 0);
        chk("rst_mid_err", err_slv, 0);
        step(2);
        PRESET = 1'b0;
        step(1);

        // TX eligibility with the bridge TX FIFO not empty
        cfg_word = 14'h001; tmo_word = 14'h002; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cfg_done) begin ok = 1'b1; break; end
        end
        chk("thr_cfg_done", ok, 1);
        b = n_lg; t = n_txr;
        INT_TX = 1'b0; tx_valid = 1'b1; tx_data = 32'h12345678;
`ifdef APB_SEQ_TX_THROTTLE_EN
        step(10);
        chk("thr_blocked", n_txr - t, 0);
        INT_TX = 1'b1;
`endif
        step(1);
        chk("thr_tx_ready", tx_ready, 1);
        tx_valid = 1'b0;
        step(4);
        chk("thr_n_xfers", n_lg - b, 1);
        chk("thr_wd", lg_wd[b], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
